imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe.sv | 174 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a two-entry skid buffer.
// The immediate is decoded combinationally from the incoming instruction and
// captured into the output register, or into the skid register when the
// output register is occupied and the consumer is stalling.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_cnt
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] T_I  = 3'd0;
  localparam logic [2:0] T_S  = 3'd1;
  localparam logic [2:0] T_B  = 3'd2;
  localparam logic [2:0] T_J  = 3'd3;
  localparam logic [2:0] T_U  = 3'd4;
  localparam logic [2:0] T_Z  = 3'd5;
  localparam logic [2:0] T_SH = 3'd6;
  localparam logic [2:0] T_RS = 3'd7;

  // Extract and extend the immediate for the selected format.
  function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] inst,
                                                     input logic [2:0]  t);
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    s12 = '0;
    s13 = '0;
    s21 = '0;
    s32 = '0;
    gen_imm = '0;
    case (t)
      T_I: begin
        s12 = $signed(inst[31:20]);
        gen_imm = XLEN'(s12);
      end
      T_S: begin
        s12 = $signed({inst[31:25], inst[11:7]});
        gen_imm = XLEN'(s12);
      end
      T_B: begin
        s13 = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        gen_imm = XLEN'(s13);
      end
      T_J: begin
        s21 = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
        gen_imm = XLEN'(s21);
      end
      T_U: begin
        s32 = $signed({inst[31:12], 12'b0});
        gen_imm = XLEN'(s32);
      end
      T_Z:  gen_imm = $signed(XLEN'(inst[19:15]));
      T_SH: gen_imm = (XLEN == 64) ? $signed(XLEN'(inst[25:20]))
                                   : $signed(XLEN'(inst[24:20]));
      default: gen_imm = '0;
    endcase
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic signed [XLEN-1:0] imm_p0;
  logic                   err_p0;

  logic                   vld_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic                   err_p1;
  logic [TAG_W-1:0]       tag_p1;

  logic                   sk_vld_p1;
  logic signed [XLEN-1:0] sk_imm_p1;
  logic                   sk_err_p1;
  logic [TAG_W-1:0]       sk_tag_p1;

  logic [CNT_W-1:0]       cnt;

  logic accept;
  logic pop;
  logic move_sk;
  logic load_or;
  logic load_sk;

  assign imm_p0 = gen_imm(in_inst, in_imm_type);
  assign err_p0 = (in_imm_type == T_RS);

  // Ready depends only on registered skid state and reset, never on out_ready.
  assign in_ready = !sk_vld_p1 && !rst;
  assign accept   = in_valid && in_ready;
  assign pop      = vld_p1 && out_ready;
  assign move_sk  = pop && sk_vld_p1;
  assign load_or  = accept && (!vld_p1 || pop);
  assign load_sk  = accept && vld_p1 && !pop;

  // ---- stage p0 -> p1 boundary ----

  // Occupancy of output and skid registers plus the error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      sk_vld_p1 <= 1'b0;
      cnt       <= '0;
    end else begin
      if (load_or || move_sk) begin
        vld_p1 <= 1'b1;
      end else if (pop) begin
        vld_p1 <= 1'b0;
      end
      if (move_sk) begin
        sk_vld_p1 <= 1'b0;
      end else if (load_sk) begin
        sk_vld_p1 <= 1'b1;
      end
      if (accept && err_p0) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

  // Output register contents; cleared on reset so idle outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_p1 <= '0;
      err_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (move_sk) begin
      imm_p1 <= sk_imm_p1;
      err_p1 <= sk_err_p1;
      tag_p1 <= sk_tag_p1;
    end else if (load_or) begin
      imm_p1 <= imm_p0;
      err_p1 <= err_p0;
      tag_p1 <= in_tag;
    end
  end

  // Skid register contents; only meaningful while sk_vld_p1 is set.
  always_ff @(posedge clk) begin
    if (load_sk) begin
      sk_imm_p1 <= imm_p0;
      sk_err_p1 <= err_p0;
      sk_tag_p1 <= in_tag;
    end
  end

  assign out_valid = vld_p1;
  assign out_imm   = imm_p1;
  assign out_err   = err_p1;
  assign out_tag   = tag_p1;
  assign err_cnt   = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit instance with the default counter
// width and a 64-bit instance with a 2-bit counter share the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_type;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_imm;
  logic [3:0]  a_out_tag;
  logic [7:0]  a_err_cnt;

  logic        b_in_ready, b_out_valid, b_out_err;
  logic [63:0] b_out_imm;
  logic [3:0]  b_out_tag;
  logic [1:0]  b_err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_err(a_out_err), .out_tag(a_out_tag),
    .err_cnt(a_err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(4), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_err(b_out_err), .out_tag(b_out_tag),
    .err_cnt(b_err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Present one item and advance one clock; input drops afterwards.
  task automatic send(input logic [2:0] t, input logic [31:0] inst, input logic [3:0] tag);
    in_valid    = 1'b1;
    in_imm_type = t;
    in_inst     = inst;
    in_tag      = tag;
    @(posedge clk); #1;
    in_valid    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Check an item sitting in both output registers.
  task automatic chk_out(input string name, input logic [31:0] e32, input logic [63:0] e64,
                         input logic err, input logic [3:0] tag);
    chk({name, "_vld32"}, 64'(a_out_valid), 64'd1);
    chk({name, "_vld64"}, 64'(b_out_valid), 64'd1);
    chk({name, "_imm32"}, 64'(a_out_imm), 64'(e32));
    chk({name, "_imm64"}, b_out_imm, e64);
    chk({name, "_err"},   64'(a_out_err), 64'(err));
    chk({name, "_tag"},   64'(a_out_tag), 64'(tag));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_imm_type = '0; in_tag = '0;
    out_ready = 1'b1;
    tick(); tick();
    chk("in_ready_in_rst", 64'(a_in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_imm",   64'(a_out_imm),   64'd0);
    chk("rst_out_err",   64'(a_out_err),   64'd0);
    chk("rst_out_tag",   64'(a_out_tag),   64'd0);
    chk("rst_err_cnt",   64'(a_err_cnt),   64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);

    // Formats, streamed back to back with the consumer always ready.
    send(3'd0, 32'hFFF00093, 4'd1);
    chk_out("i_neg1", 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 4'd1);
    send(3'd1, 32'h02A00523, 4'd2);
    chk_out("s_42", 32'h0000002A, 64'h2A, 1'b0, 4'd2);
    send(3'd2, 32'hFE000EE3, 4'd3);
    chk_out("b_m4", 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 4'd3);
    send(3'd3, 32'h8000006F, 4'd4);
    chk_out("j_min", 32'hFFF00000, 64'hFFFFFFFF_FFF00000, 1'b0, 4'd4);
    send(3'd4, 32'h123450B7, 4'd5);
    chk_out("u_pos", 32'h12345000, 64'h00000000_12345000, 1'b0, 4'd5);
    send(3'd4, 32'h80000037, 4'd6);
    chk_out("u_neg", 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0, 4'd6);
    send(3'd5, 32'hFFFFFFFF, 4'd7);
    chk_out("zimm", 32'h0000001F, 64'h1F, 1'b0, 4'd7);
    send(3'd6, 32'hFFFFFFFF, 4'd8);
    chk_out("shamt", 32'h0000001F, 64'h3F, 1'b0, 4'd8);
    send(3'd7, 32'hFFFFFFFF, 4'd9);
    chk_out("rsvd", 32'h0, 64'h0, 1'b1, 4'd9);
    chk("rsvd_cnt32", 64'(a_err_cnt), 64'd1);
    chk("rsvd_cnt64", 64'(b_err_cnt), 64'd1);

    // Four more reserved items: the 2-bit counter saturates.
    send(3'd7, 32'h0, 4'd10);
    send(3'd7, 32'h0, 4'd11);
    send(3'd7, 32'h0, 4'd12);
    send(3'd7, 32'h0, 4'd13);
    chk("sat_cnt64", 64'(b_err_cnt), 64'd3);
    chk("cnt32_5",   64'(a_err_cnt), 64'd5);
    tick();
    chk("drain_empty", 64'(a_out_valid), 64'd0);

    // Backpressure: fill OR and SK, then hold a third item at the input.
    out_ready = 1'b0;
    send(3'd0, 32'h00100093, 4'd1);
    chk("bp_rdy_after1", 64'(a_in_ready), 64'd1);
    send(3'd0, 32'h00200093, 4'd2);
    chk("bp_rdy_after2", 64'(a_in_ready), 64'd0);
    chk("bp_tag_or", 64'(a_out_tag), 64'd1);
    in_valid = 1'b1; in_imm_type = 3'd0; in_inst = 32'h00300093; in_tag = 4'd3;
    tick(); tick();
    chk("bp_stable_tag", 64'(a_out_tag), 64'd1);
    chk("bp_stable_imm", 64'(a_out_imm), 64'd1);
    chk("bp_stable_vld", 64'(a_out_valid), 64'd1);
    chk("bp_still_full", 64'(a_in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_tag2",    64'(a_out_tag), 64'd2);
    chk("bp_imm2",    64'(b_out_imm), 64'd2);
    chk("bp_rdy_fre", 64'(a_in_ready), 64'd1);
    tick();
    chk("bp_tag3", 64'(a_out_tag), 64'd3);
    in_inst = 32'h00400093; in_tag = 4'd4;
    tick();
    in_valid = 1'b0;
    chk("bp_tag4", 64'(a_out_tag), 64'd4);
    chk("bp_imm4", 64'(a_out_imm), 64'd4);
    tick();
    chk("bp_done", 64'(a_out_valid), 64'd0);

    // Reset while both registers hold items; input offered during reset.
    out_ready = 1'b0;
    send(3'd7, 32'h0, 4'd5);
    send(3'd0, 32'h00600093, 4'd6);
    chk("full_before_rst", 64'(a_in_ready), 64'd0);
    rst = 1'b1;
    in_valid = 1'b1; in_imm_type = 3'd0; in_inst = 32'h00900093; in_tag = 4'd9;
    tick();
    chk("mid_rst_vld",  64'(a_out_valid), 64'd0);
    chk("mid_rst_cnt",  64'(a_err_cnt),   64'd0);
    chk("mid_rst_cnt64", 64'(b_err_cnt),  64'd0);
    chk("mid_rst_rdy",  64'(a_in_ready),  64'd0);
    tick();
    chk("mid_rst_noacc", 64'(a_out_valid), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(a_in_ready), 64'd1);
    send(3'd0, 32'h00700093, 4'd7);
    chk_out("post_rst_lat1", 32'h7, 64'h7, 1'b0, 4'd7);
    tick();
    chk("post_rst_drain", 64'(a_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
